// File: rtl/rect_draw_pkg.sv
// -----------------------------------------------------------------------------
// rect_draw_pkg
// Shared constants and types for the rectangle draw scheduler.
//   X_W / Y_W / COL_W     : VGA adapter coordinate and colour widths
//   SCREEN_W_DEF/_H_DEF   : default visible screen size (160x120)
//   state_e               : scheduler FSM encoding
// Optional build macro: CLEAR_ON_RESET_EN adds the CLEAR state that wipes
// the screen after reset release.
// -----------------------------------------------------------------------------
package rect_draw_pkg;

  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int COL_W        = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

`ifdef CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: finds the first set request at or
// above the pointer, wrapping past the top client.
//   req_i       : per-client request vector
//   ptr_i       : index of the highest-priority client (always < NUM_REQ)
//   gnt_next_o  : one-hot winner, all zero when nothing is requested
//   index_o     : binary index of the winner (0 when nothing is requested)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_next_o,
  output logic [IDX_W-1:0]   index_o
);

  logic [2*NUM_REQ-1:0] reqDbl;
  logic [2*NUM_REQ-1:0] rot;
  logic [IDX_W:0]       sum;
  logic                 found;

  // Rotating a doubled copy right by the pointer puts the highest-priority
  // client at bit 0, so a plain lowest-bit-first search gives round-robin.
  // The winner's real index is the rotation offset added back modulo NUM_REQ.
  always_comb begin
    reqDbl  = {req_i, req_i};
    rot     = reqDbl >> ptr_i;
    found   = 1'b0;
    sum     = '0;
    index_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
          sum = sum - (IDX_W+1)'(NUM_REQ);
        end
        index_o = sum[IDX_W-1:0];
      end
    end
  end

  assign gnt_next_o = found ? (NUM_REQ'(1) << index_o) : '0;

endmodule

// File: rtl/rect_draw_scheduler.sv
// -----------------------------------------------------------------------------
// rect_draw_scheduler
// Shares the single VGA adapter pixel port between NUM_REQ rectangle clients.
// A client is picked round-robin in IDLE, its rectangle is scanned row-major
// one pixel per cycle (off-screen pixels are clipped but still take a cycle),
// then done is pulsed to that client for one cycle.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   req_i            : level request per client
//   rect_x_i/_y_i    : packed origin per client (8 / 7 bits each)
//   rect_w_i/_h_i    : packed size per client (0 is legal, draws nothing)
//   rect_colour_i    : packed colour per client (3 bits each)
//   gnt_o            : one-hot grant, high for the whole service
//   done_o           : one-cycle completion pulse to the served client
//   vga_x_o/_y_o     : pixel coordinate, vga_colour_o : pixel colour
//   plot_o           : VGA write enable
//   busy_o           : high whenever the FSM is not IDLE
// Optional build macro: CLEAR_ON_RESET_EN -- after reset release the whole
// screen is swept with colour 000 before any request is served.
// -----------------------------------------------------------------------------
module rect_draw_scheduler
  import rect_draw_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [X_W*NUM_REQ-1:0]   rect_x_i,
  input  logic [Y_W*NUM_REQ-1:0]   rect_y_i,
  input  logic [X_W*NUM_REQ-1:0]   rect_w_i,
  input  logic [Y_W*NUM_REQ-1:0]   rect_h_i,
  input  logic [COL_W*NUM_REQ-1:0] rect_colour_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [X_W-1:0]           vga_x_o,
  output logic [Y_W-1:0]           vga_y_o,
  output logic [COL_W-1:0]         vga_colour_o,
  output logic                     plot_o,
  output logic                     busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [X_W-1:0]     x_q, x_d, w_q, w_d, cx_q, cx_d, lastX_q, lastX_d;
  logic [Y_W-1:0]     y_q, y_d, h_q, h_d, cy_q, cy_d, lastY_q, lastY_d;
  logic [COL_W-1:0]   col_q, col_d, lastCol_q, lastCol_d;
`ifdef CLEAR_ON_RESET_EN
  logic               clearPending_q, clearPending_d;
`endif

  logic [X_W-1:0]     reqX   [NUM_REQ];
  logic [Y_W-1:0]     reqY   [NUM_REQ];
  logic [X_W-1:0]     reqW   [NUM_REQ];
  logic [Y_W-1:0]     reqH   [NUM_REQ];
  logic [COL_W-1:0]   reqCol [NUM_REQ];

  logic [NUM_REQ-1:0] arbGnt;
  logic [IDX_W-1:0]   arbIdx;

  // One extra bit so coordinates that run past 255 / 127 are seen as
  // off-screen instead of wrapping back onto the visible area.
  logic [X_W:0]       xSum;
  logic [Y_W:0]       ySum;
  logic               inView;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqX[i]   = rect_x_i[X_W*i +: X_W];
    assign reqY[i]   = rect_y_i[Y_W*i +: Y_W];
    assign reqW[i]   = rect_w_i[X_W*i +: X_W];
    assign reqH[i]   = rect_h_i[Y_W*i +: Y_W];
    assign reqCol[i] = rect_colour_i[COL_W*i +: COL_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i      (req_i),
    .ptr_i      (ptr_q),
    .gnt_next_o (arbGnt),
    .index_o    (arbIdx)
  );

  assign xSum   = {1'b0, x_q} + {1'b0, cx_q};
  assign ySum   = {1'b0, y_q} + {1'b0, cy_q};
  assign inView = (xSum < (X_W+1)'(SCREEN_W)) && (ySum < (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      idx_q          <= '0;
      gnt_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      w_q            <= '0;
      h_q            <= '0;
      col_q          <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      lastX_q        <= '0;
      lastY_q        <= '0;
      lastCol_q      <= '0;
`ifdef CLEAR_ON_RESET_EN
      clearPending_q <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      gnt_q          <= gnt_d;
      x_q            <= x_d;
      y_q            <= y_d;
      w_q            <= w_d;
      h_q            <= h_d;
      col_q          <= col_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      lastX_q        <= lastX_d;
      lastY_q        <= lastY_d;
      lastCol_q      <= lastCol_d;
`ifdef CLEAR_ON_RESET_EN
      clearPending_q <= clearPending_d;
`endif
    end
  end

  // The last* registers remember what was on the pixel bus during the final
  // SCAN/CLEAR cycle so the bus holds still whenever plot is low.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    idx_d          = idx_q;
    gnt_d          = gnt_q;
    x_d            = x_q;
    y_d            = y_q;
    w_d            = w_q;
    h_d            = h_q;
    col_d          = col_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    lastX_d        = lastX_q;
    lastY_d        = lastY_q;
    lastCol_d      = lastCol_q;
`ifdef CLEAR_ON_RESET_EN
    clearPending_d = clearPending_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef CLEAR_ON_RESET_EN
        if (clearPending_q) begin
          clearPending_d = 1'b0;
          cx_d           = '0;
          cy_d           = '0;
          state_d        = ST_CLEAR;
        end else
`endif
        if (|req_i) begin
          idx_d   = arbIdx;
          gnt_d   = arbGnt;
          x_d     = reqX[arbIdx];
          y_d     = reqY[arbIdx];
          w_d     = reqW[arbIdx];
          h_d     = reqH[arbIdx];
          col_d   = reqCol[arbIdx];
          cx_d    = '0;
          cy_d    = '0;
          state_d = ((reqW[arbIdx] == '0) || (reqH[arbIdx] == '0)) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        lastX_d   = xSum[X_W-1:0];
        lastY_d   = ySum[Y_W-1:0];
        lastCol_d = col_q;
        if (cx_q == w_q - X_W'(1)) begin
          cx_d = '0;
          if (cy_q == h_q - Y_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + IDX_W'(1);
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
`ifdef CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        lastX_d   = cx_q;
        lastY_d   = cy_q;
        lastCol_d = '0;
        if (cx_q == X_W'(SCREEN_W-1)) begin
          cx_d = '0;
          if (cy_q == Y_W'(SCREEN_H-1)) begin
            cy_d    = '0;
            state_d = ST_IDLE;
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel bus is driven live from the scan counters so pixel k lands in the
  // k-th SCAN cycle; elsewhere it replays the held values with plot low.
  always_comb begin
    plot_o       = 1'b0;
    vga_x_o      = lastX_q;
    vga_y_o      = lastY_q;
    vga_colour_o = lastCol_q;
    case (state_q)
      ST_SCAN: begin
        plot_o       = inView;
        vga_x_o      = xSum[X_W-1:0];
        vga_y_o      = ySum[Y_W-1:0];
        vga_colour_o = col_q;
      end
`ifdef CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        plot_o       = 1'b1;
        vga_x_o      = cx_q;
        vga_y_o      = cy_q;
        vga_colour_o = '0;
      end
`endif
      default: ;
    endcase
  end

  assign gnt_o  = gnt_q;
  assign done_o = (state_q == ST_DONE) ? gnt_q : '0;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rect_draw_scheduler
// Self-checking bench for rect_draw_scheduler (NUM_REQ = 2, 160x120 screen).
// Expected pixels and done pulses come from a small rectangle/clipping model
// and sit in queues until the DUT produces them.
// -----------------------------------------------------------------------------
module tb_rect_draw_scheduler;

  localparam int NUM_REQ = 2;
  localparam int SW      = 160;
  localparam int SH      = 120;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req;
  logic [8*NUM_REQ-1:0]   rectX, rectW;
  logic [7*NUM_REQ-1:0]   rectY, rectH;
  logic [3*NUM_REQ-1:0]   rectCol;
  logic [NUM_REQ-1:0]     gnt, done;
  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [2:0]             vga_colour;
  logic                   plot, busy;

  typedef struct { int client; int x; int y; int w; int h; int col; } vec_t;
  typedef struct { int x; int y; int col; int client; } pix_t;

  pix_t pixQ[$];
  int   doneQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   monEnable = 1'b0;
  int   ptrModel = 0;
  vec_t vecs[8];

  always #5 clock = ~clock;

  rect_draw_scheduler #(.NUM_REQ(NUM_REQ), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_i         (req),
    .rect_x_i      (rectX),
    .rect_y_i      (rectY),
    .rect_w_i      (rectW),
    .rect_h_i      (rectH),
    .rect_colour_i (rectCol),
    .gnt_o         (gnt),
    .done_o        (done),
    .vga_x_o       (vga_x),
    .vga_y_o       (vga_y),
    .vga_colour_o  (vga_colour),
    .plot_o        (plot),
    .busy_o        (busy)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic void pushModel(input vec_t v);
    for (int yy = 0; yy < v.h; yy++) begin
      for (int xx = 0; xx < v.w; xx++) begin
        if ((v.x + xx) < SW && (v.y + yy) < SH) begin
          pixQ.push_back('{v.x + xx, v.y + yy, v.col, v.client});
        end
      end
    end
    doneQ.push_back(v.client);
  endfunction

  function automatic int countVisible(input vec_t v);
    int n = 0;
    for (int yy = 0; yy < v.h; yy++)
      for (int xx = 0; xx < v.w; xx++)
        if ((v.x + xx) < SW && (v.y + yy) < SH) n++;
    return n;
  endfunction

  task automatic setRect(input vec_t v);
    rectX[8*v.client +: 8]   = v.x[7:0];
    rectY[7*v.client +: 7]   = v.y[6:0];
    rectW[8*v.client +: 8]   = v.w[7:0];
    rectH[7*v.client +: 7]   = v.h[6:0];
    rectCol[3*v.client +: 3] = v.col[2:0];
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    setRect(v);
    req = '0;
    req[v.client] = 1'b1;
    pushModel(v);
  endtask

  // Scoreboard: every plotted pixel and every done pulse must match the
  // head of its queue.
  always @(negedge clock) begin
    pix_t p;
    int   dc;
    if (monEnable && reset_n) begin
      if (plot) begin
        if (pixQ.size() == 0) begin
          checkOutput("unexpected plot", 1, 0);
        end else begin
          p = pixQ.pop_front();
          checkOutput("pixel x", int'(vga_x), p.x);
          checkOutput("pixel y", int'(vga_y), p.y);
          checkOutput("pixel colour", int'(vga_colour), p.col);
          checkOutput("gnt during plot", int'(gnt), 1 << p.client);
        end
      end
      if (done != '0) begin
        if (doneQ.size() == 0) begin
          checkOutput("unexpected done", int'(done), 0);
        end else begin
          dc = doneQ.pop_front();
          checkOutput("done vector", int'(done), 1 << dc);
          checkOutput("plot in done cycle", int'(plot), 0);
        end
      end
    end
  end

  task automatic runRect(input vec_t v);
    int c, dc, plots, expDone;
    bit gntOk;
    applyStimulus(v);
    expDone = 1 + v.w * v.h;
    c = 0; dc = -1; plots = 0; gntOk = 1'b1;
    while (dc < 0 && c < expDone + 20) begin
      @(negedge clock);
      c++;
      if (c == 1) req = '0;
      if (plot) plots++;
      if (gnt !== NUM_REQ'(1 << v.client)) gntOk = 1'b0;
      if (done != '0) dc = c;
    end
    checkOutput("done cycle", dc, expDone);
    checkOutput("gnt held through service", int'(gntOk), 1);
    checkOutput("plot count", plots, countVisible(v));
    if (v.w * v.h > 0) begin
      checkOutput("held x after scan", int'(vga_x), (v.x + v.w - 1) % 256);
      checkOutput("held y after scan", int'(vga_y), (v.y + v.h - 1) % 128);
    end
    ptrModel = (v.client + 1) % NUM_REQ;
  endtask

  // Both clients hold 1x1 requests; service must alternate starting at the
  // modelled pointer, with a done every three cycles.
  task automatic runFairness();
    vec_t a, b;
    int   first, nDone, c;
    int   doneAt[4];
    a = '{0, 1, 1, 1, 1, 2};
    b = '{1, 2, 2, 1, 1, 3};
    first = ptrModel;
    for (int k = 0; k < 4; k++) doneAt[k] = -1;
    @(negedge clock);
    setRect(a);
    setRect(b);
    req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      if (first == 0) begin pushModel(a); pushModel(b); end
      else begin pushModel(b); pushModel(a); end
    end
    nDone = 0; c = 0;
    while (nDone < 4 && c < 40) begin
      @(negedge clock);
      c++;
      if (done != '0) begin
        doneAt[nDone] = c;
        nDone++;
        if (nDone == 4) req = '0;
      end
    end
    req = '0;
    checkOutput("fairness done count", nDone, 4);
    for (int k = 0; k < 4; k++) checkOutput("fairness done timing", doneAt[k], 2 + 3 * k);
  endtask

`ifdef CLEAR_ON_RESET_EN
  task automatic waitClear();
    int n = 0;
    @(negedge clock);
    while (busy && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("clear sweep finished", int'(busy), 0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{0,  10,  20, 3, 2, 4};
    vecs[1] = '{1, 158, 119, 4, 2, 6};
    vecs[2] = '{0, 255,   0, 2, 1, 5};
    vecs[3] = '{1, 100, 127, 1, 2, 3};
    vecs[4] = '{1,   0,   0, 4, 0, 2};
    vecs[5] = '{0, 157, 118, 5, 3, 1};
    vecs[6] = '{1,  30,  40, 2, 2, 7};
    vecs[7] = '{0,  50,  50, 0, 5, 3};

    reset_n = 1'b0;
    req     = '0;
    rectX   = '0; rectY = '0; rectW = '0; rectH = '0; rectCol = '0;

    #3;
    checkOutput("reset gnt", int'(gnt), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset plot", int'(plot), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset vga_x", int'(vga_x), 0);
    checkOutput("reset vga_y", int'(vga_y), 0);
    checkOutput("reset vga_colour", int'(vga_colour), 0);
    @(negedge clock);
    @(negedge clock);

`ifdef CLEAR_ON_RESET_EN
    begin
      vec_t cv;
      int   e, bad, n;
      cv = '{0, 3, 4, 1, 1, 2};
      setRect(cv);
      req = 2'b01;
      @(negedge clock);
      reset_n = 1'b1;
      e = 0; bad = 0; n = 0;
      @(negedge clock);
      while (busy && n < 20000) begin
        if (!plot || vga_x != e % SW || vga_y != e / SW || vga_colour != 0 || gnt != 0) bad++;
        e++; n++;
        @(negedge clock);
      end
      checkOutput("clear pixel count", e, SW * SH);
      checkOutput("clear bad pixels", bad, 0);
      pushModel(cv);
      monEnable = 1'b1;
      @(negedge clock);
      checkOutput("gnt right after clear", int'(gnt), 1);
      req = '0;
      n = 0;
      while (done == '0 && n < 10) begin
        @(negedge clock);
        n++;
      end
      checkOutput("done after clear", int'(done), 1);
      ptrModel = 1;
    end
`else
    @(negedge clock);
    reset_n = 1'b1;
    monEnable = 1'b1;
`endif

    for (int i = 0; i < 8; i++) runRect(vecs[i]);

    runFairness();

    begin
      int  c;
      bit  doneSeen;
      vec_t r;
      r = '{0, 0, 0, 10, 10, 5};
      monEnable = 1'b0;
      @(negedge clock);
      setRect(r);
      req = 2'b01;
      for (c = 1; c <= 3; c++) @(negedge clock);
      checkOutput("plot before mid-scan reset", int'(plot), 1);
      checkOutput("x before mid-scan reset", int'(vga_x), 2);
      req = '0;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset gnt", int'(gnt), 0);
      checkOutput("async reset plot", int'(plot), 0);
      checkOutput("async reset busy", int'(busy), 0);
      doneSeen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        if (done != '0) doneSeen = 1'b1;
      end
      reset_n = 1'b1;
`ifdef CLEAR_ON_RESET_EN
      waitClear();
`endif
      @(negedge clock);
      if (done != '0) doneSeen = 1'b1;
      checkOutput("no done after abort", int'(doneSeen), 0);
      pixQ.delete();
      doneQ.delete();
      ptrModel = 0;
      monEnable = 1'b1;
    end

    runFairness();
    runRect('{1, 5, 6, 2, 3, 6});

    repeat (3) @(negedge clock);
    checkOutput("pixel queue drained", pixQ.size(), 0);
    checkOutput("done queue drained", doneQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_draw_scheduler.md
Name: rect_draw_scheduler

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) between NUM_REQ rectangle-drawing clients, e.g. stair draw/erase controllers.
- Each client raises a level request carrying a rectangle (origin, width, height, colour).
- The scheduler grants one client at a time in round-robin order and scans that rectangle one pixel per cycle, row-major.
- It pulses done to the served client when the scan completes.
- Sits between the per-object control FSMs and the VGA adapter, replacing ad-hoc muxing of drawer outputs.

Parameters:
- NUM_REQ, 2, number of requesting clients (2..8).
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per client
- rect_x  in  8*NUM_REQ  origin x per client, client i at [8i+7:8i]
- rect_y  in  7*NUM_REQ  origin y per client
- rect_w  in  8*NUM_REQ  width in pixels; 0 is legal
- rect_h  in  7*NUM_REQ  height in pixels; 0 is legal
- rect_colour  in  3*NUM_REQ  colour per client
- gnt  out  NUM_REQ  one-hot grant; high for the whole service
- done  out  NUM_REQ  one-cycle completion pulse to the served client
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- plot  out  1  write enable to the VGA adapter
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: already decided — reset reset_n, asynchronous, active-low; clock clock. On assertion:
  - state IDLE; gnt, done, plot, busy = 0; vga_x, vga_y, vga_colour = 0.
  - round-robin pointer = 0; scan counters = 0.
- States: IDLE, SCAN, DONE (plus CLEAR, see Optional Feature).
- IDLE:
  - If req != 0 on a rising edge, select the first set req[i] searching from the pointer upward with wrap.
  - Latch the client's x, y, w, h, colour; set gnt[i].
  - Go to SCAN, or straight to DONE if w == 0 or h == 0.
  - Request inputs are sampled only in IDLE. Changes during service are ignored.
- SCAN:
  - Column counter cx runs 0..w-1; row counter cy increments when cx wraps, over 0..h-1.
  - vga_x = latched_x + cx and vga_y = latched_y + cy, computed 9/8 bits wide internally, then truncated.
  - plot = 1 only when the untruncated x < SCREEN_W and y < SCREEN_H. Clipped pixels still consume their cycle.
  - Exactly w*h SCAN cycles. After the cycle with cx = w-1 and cy = h-1, go to DONE.
- DONE (one cycle):
  - done[i] = 1, plot = 0.
  - Pointer = (i+1) mod NUM_REQ.
  - Next: IDLE, with gnt cleared on entry to IDLE.
- Timing: with req sampled in IDLE at cycle 0, pixel k (0-based) appears in cycle 1+k and done appears in cycle 1+w*h.
- Outputs: vga_colour is held at the latched colour through SCAN. Outside SCAN, vga_x, vga_y and vga_colour hold their last value while plot = 0.
- Client protocol:
  - req is level-sensitive. A client must drop req in the cycle after done, or it is re-eligible.
  - Round-robin still prevents it from starving others.
- Reset mid-SCAN: immediate abort. No done is issued and the partial rectangle is left on screen.

Optional Feature:
- Macro: CLEAR_ON_RESET_EN.
- Defined: after reset release the FSM enters CLEAR.
  - Sweeps all SCREEN_W*SCREEN_H pixels row-major with colour 000 and plot = 1, one per cycle.
  - busy = 1 and req is ignored throughout; then goes to IDLE.
  - A reset during CLEAR restarts the sweep.
- Undefined: the CLEAR state and its counters are absent; reset goes directly to IDLE.

Decomposition:
- Package rect_draw_pkg: SCREEN_W/SCREEN_H defaults, coordinate widths (X_W = 8, Y_W = 7, COL_W = 3), state encoding constants.
- Sub-module rr_arbiter (NUM_REQ): inputs req and pointer; outputs one-hot gnt_next and index.
  - Purely combinational, instantiated once.
  - Pixel scan counters stay in the top module.

Test Plan:
- Single client: req[0] with (10, 20, w 3, h 2, colour 100).
  - Expected: gnt[0] in cycles 1–7.
  - plot in cycles 1–6 at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21).
  - done[0] in cycle 7.
- Fairness: req = 11 held continuously, 1x1 rectangles.
  - Expected: service order 0, 1, 0, 1.
  - done pulses alternate every 3 cycles.
- Clipping: (158, 119, w 4, h 2).
  - Expected: plot only for (158,119) and (159,119).
  - 8 SCAN cycles; done in cycle 9.
- Degenerate rectangle: w = 0, h = 5.
  - Expected: no plot; done[i] in cycle 1; pointer advances.
- Reset mid-SCAN: reset_n low in cycle 3 of a 10x10 rectangle.
  - Expected: gnt, plot and busy go to 0 asynchronously; no done.
  - A new request is served correctly after release.
- CLEAR_ON_RESET_EN: release reset with req[0] already high.
  - Expected: 19200 plot cycles with colour 000 covering (0,0)..(159,119) and busy = 1.
  - Then IDLE, and req[0] is granted on the next edge.
